// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: serialises two requesters onto one single-port RAM with a fixed
// IDLE/ISSUE/WAIT/DONE handshake. Define ARB_ROUND_ROBIN_EN for round-robin ties (else requester 0 wins).
module bram_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   input  logic [DATA_WIDTH-1:0] ram_out
);

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic                    grant_s;
   logic                    win_s;
   logic                    gnt_id_r;
   logic                    last_gnt_r;
   logic                    op_we_r;
   logic                    ack0_r;
   logic                    ack1_r;
   logic [DATA_WIDTH-1:0]   rdata0_r;
   logic [DATA_WIDTH-1:0]   rdata1_r;
   logic                    ram_we_r;
   logic [ADDR_WIDTH-1:0]   ram_addr_r;
   logic [DATA_WIDTH-1:0]   ram_data_r;

   // Arbitration: pick the winner among currently raised requests
   always_comb begin
      grant_s = 1'b0;
      win_s   = 1'b0;
      if (req0 && req1) begin
         grant_s = 1'b1;
         win_s   = RR_EN ? ~last_gnt_r : 1'b0;
      end else if (req0) begin
         grant_s = 1'b1;
         win_s   = 1'b0;
      end else if (req1) begin
         grant_s = 1'b1;
         win_s   = 1'b1;
      end else begin
         grant_s = 1'b0;
         win_s   = 1'b0;
      end
   end

   // Next-state logic; requests only matter in IDLE
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_next_s = ST_WAIT;
         ST_WAIT:  state_next_s = ST_DONE;
         ST_DONE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // RAM pin drive, read-data capture, ack pulse and grant history
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_id_r   <= 1'b0;
         last_gnt_r <= 1'b1;
         op_we_r    <= 1'b0;
         ack0_r     <= 1'b0;
         ack1_r     <= 1'b0;
         rdata0_r   <= {DATA_WIDTH{1'b0}};
         rdata1_r   <= {DATA_WIDTH{1'b0}};
         ram_we_r   <= 1'b0;
         ram_addr_r <= {ADDR_WIDTH{1'b0}};
         ram_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  gnt_id_r   <= win_s;
                  op_we_r    <= win_s ? we1 : we0;
                  ram_we_r   <= win_s ? we1 : we0;
                  ram_addr_r <= win_s ? addr1 : addr0;
                  ram_data_r <= win_s ? wdata1 : wdata0;
               end
            end
            ST_ISSUE: begin
               // RAM samples at this edge; only the write strobe is withdrawn
               ram_we_r <= 1'b0;
            end
            ST_WAIT: begin
               if (!op_we_r) begin
                  if (gnt_id_r) begin
                     rdata1_r <= ram_out;
                  end else begin
                     rdata0_r <= ram_out;
                  end
               end
               if (gnt_id_r) begin
                  ack1_r <= 1'b1;
               end else begin
                  ack0_r <= 1'b1;
               end
            end
            ST_DONE: begin
               ack0_r     <= 1'b0;
               ack1_r     <= 1'b0;
               last_gnt_r <= gnt_id_r;
            end
            default: begin
               ack0_r   <= 1'b0;
               ack1_r   <= 1'b0;
               ram_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign ack0     = ack0_r;
   assign ack1     = ack1_r;
   assign rdata0   = rdata0_r;
   assign rdata1   = rdata1_r;
   assign ram_we   = ram_we_r;
   assign ram_addr = ram_addr_r;
   assign ram_data = ram_data_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: behavioural RAM, transaction-level reference
// model (memory image, last grant, per-requester read data) and directed plus random scenarios.
module tb_bram_port_arbiter;
   localparam int AW = 4;
   localparam int DW = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_MODEL = 1'b1;
`else
   localparam bit RR_MODEL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] ram_out;

   logic [DW-1:0] ram_mem   [1<<AW];
   logic [DW-1:0] model_mem [1<<AW];
   logic [DW-1:0] exp_rdata [2];
   logic          model_last;
   int            n_checks = 0;
   int            n_pass   = 0;

   bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
   );

   always #5 clk = ~clk;

   // single_port_ram: synchronous write, registered read output
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      ram_out <= ram_mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      model_last   = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      n_checks++; if ({ack1, ack0} !== 2'b00) $display("FAIL reset_ack got=%b exp=00", {ack1, ack0}); else n_pass++;
      n_checks++; if ({rdata1, rdata0} !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", {rdata1, rdata0}); else n_pass++;
      n_checks++; if ({ram_we, ram_addr, ram_data} !== 9'h000) $display("FAIL reset_ram got=%b/%h/%h exp=0/0/0", ram_we, ram_addr, ram_data); else n_pass++;
   endtask

   task automatic test_single_write();
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 4'hA;
      tick();
      n_checks++; if ({ram_we, ram_addr, ram_data} !== {1'b1, 4'h3, 4'hA}) $display("FAIL write_pins got=%b/%h/%h exp=1/3/a", ram_we, ram_addr, ram_data); else n_pass++;
      tick();
      n_checks++; if ({ack1, ack0} !== 2'b00) $display("FAIL write_early_ack got=%b exp=00", {ack1, ack0}); else n_pass++;
      tick();
      n_checks++; if ({ack1, ack0} !== 2'b01) $display("FAIL write_ack got=%b exp=01", {ack1, ack0}); else n_pass++;
      model_mem[3] = 4'hA;
      model_last   = 1'b0;
      tick();
      req0 = 1'b0;
      n_checks++; if ({ack1, ack0} !== 2'b00) $display("FAIL write_ack_pulse got=%b exp=00", {ack1, ack0}); else n_pass++;
   endtask

   task automatic test_read_back();
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
      tick(); tick(); tick();
      exp_rdata[1] = model_mem[3];
      model_last   = 1'b1;
      n_checks++; if ({ack1, ack0} !== 2'b10) $display("FAIL read_ack got=%b exp=10", {ack1, ack0}); else n_pass++;
      n_checks++; if (rdata1 !== exp_rdata[1]) $display("FAIL read_rdata1 got=%h exp=%h", rdata1, exp_rdata[1]); else n_pass++;
      n_checks++; if (rdata0 !== exp_rdata[0]) $display("FAIL read_rdata0 got=%h exp=%h", rdata0, exp_rdata[0]); else n_pass++;
      tick();
      req1 = 1'b0;
   endtask

   task automatic test_tie();
      logic win [3];
      logic lg;
      logic exp0, exp1;
      int   k;
      lg = model_last;
      for (int i = 0; i < 3; i++) begin
         win[i] = RR_MODEL ? ~lg : 1'b0;
         lg     = win[i];
      end
      we0 = 1'b0; addr0 = 4'h3; we1 = 1'b0; addr1 = 4'hC;
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp0 = 1'b0;
         exp1 = 1'b0;
         if (c % 4 == 3) begin
            k = c / 4;
            exp0 = (win[k] == 1'b0);
            exp1 = (win[k] == 1'b1);
            exp_rdata[win[k]] = win[k] ? model_mem[12] : model_mem[3];
            model_last = win[k];
            n_checks++; if ({rdata1, rdata0} !== {exp_rdata[1], exp_rdata[0]}) $display("FAIL tie_rdata cyc=%0d got=%h exp=%h", c, {rdata1, rdata0}, {exp_rdata[1], exp_rdata[0]}); else n_pass++;
         end
         n_checks++; if ({ack1, ack0} !== {exp1, exp0}) $display("FAIL tie_ack cyc=%0d got=%b exp=%b", c, {ack1, ack0}, {exp1, exp0}); else n_pass++;
         if (c == 12) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
   endtask

   task automatic test_stale_guard();
      int n_ack0, n_ack1, n_we, first;
      n_ack0 = 0; n_ack1 = 0; n_we = 0; first = 0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h9; wdata0 = 4'h6;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (ack0 === 1'b1) begin
            n_ack0++;
            if (first == 0) first = c;
         end
         if (ack1 === 1'b1) n_ack1++;
         if (ram_we === 1'b1) n_we++;
         if (c == 4) req0 = 1'b0;
      end
      model_mem[9] = 4'h6;
      model_last   = 1'b0;
      n_checks++; if (n_ack0 != 1 || first != 3) $display("FAIL stale_ack0 count=%0d first=%0d exp=1/3", n_ack0, first); else n_pass++;
      n_checks++; if (n_ack1 != 0) $display("FAIL stale_ack1 count=%0d exp=0", n_ack1); else n_pass++;
      n_checks++; if (n_we != 1) $display("FAIL stale_we count=%0d exp=1", n_we); else n_pass++;
   endtask

   task automatic test_reset_mid_issue();
      int n_ack;
      n_ack = 0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 4'h5;
      tick();
      n_checks++; if (ram_we !== 1'b1) $display("FAIL midrst_issue_we got=%b exp=1", ram_we); else n_pass++;
      reset = 1'b1;
      req0  = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      model_mem[7] = 4'h5;
      n_checks++; if ({ram_we, ack1, ack0} !== 3'b000) $display("FAIL midrst_outputs got=%b exp=000", {ram_we, ack1, ack0}); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         tick();
         if ((ack0 | ack1) === 1'b1) n_ack++;
      end
      n_checks++; if (n_ack != 0) $display("FAIL midrst_no_ack count=%0d exp=0", n_ack); else n_pass++;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h7;
      tick(); tick(); tick();
      exp_rdata[1] = model_mem[7];
      n_checks++; if ({ack1, ack0} !== 2'b10) $display("FAIL midrst_read_ack got=%b exp=10", {ack1, ack0}); else n_pass++;
      n_checks++; if (rdata1 !== exp_rdata[1]) $display("FAIL midrst_read_data got=%h exp=%h", rdata1, exp_rdata[1]); else n_pass++;
      model_last = 1'b1;
      tick();
      req1 = 1'b0;
   endtask

   task automatic test_random();
      logic          pend [2];
      logic          wr   [2];
      logic [AW-1:0] a    [2];
      logic [DW-1:0] d    [2];
      logic          w, got;
      int            cnt, act;
      for (int it = 0; it < 40; it++) begin
         act = $urandom_range(1, 3);
         for (int r = 0; r < 2; r++) begin
            pend[r] = act[r];
            wr[r]   = 1'($urandom_range(0, 1));
            a[r]    = AW'($urandom_range(0, 15));
            d[r]    = DW'($urandom_range(0, 15));
         end
         we0 = wr[0]; addr0 = a[0]; wdata0 = d[0]; req0 = pend[0];
         we1 = wr[1]; addr1 = a[1]; wdata1 = d[1]; req1 = pend[1];
         while (pend[0] || pend[1]) begin
            w   = (pend[0] && pend[1]) ? (RR_MODEL ? ~model_last : 1'b0) : pend[1];
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 6) begin
               tick();
               cnt++;
               got = ack0 | ack1;
            end
            n_checks++; if (!got || cnt != 3) $display("FAIL rand_latency it=%0d got=%0d exp=3", it, got ? cnt : -1); else n_pass++;
            n_checks++; if ({ack1, ack0} !== (w ? 2'b10 : 2'b01)) $display("FAIL rand_winner it=%0d got=%b exp=%b", it, {ack1, ack0}, w ? 2'b10 : 2'b01); else n_pass++;
            if (wr[w]) model_mem[a[w]] = d[w];
            else       exp_rdata[w]    = model_mem[a[w]];
            model_last = w;
            n_checks++; if ({rdata1, rdata0} !== {exp_rdata[1], exp_rdata[0]}) $display("FAIL rand_rdata it=%0d got=%h exp=%h", it, {rdata1, rdata0}, {exp_rdata[1], exp_rdata[0]}); else n_pass++;
            tick();
            n_checks++; if ((ack0 | ack1) !== 1'b0) $display("FAIL rand_ack_pulse it=%0d got=%b exp=00", it, {ack1, ack0}); else n_pass++;
            pend[w] = 1'b0;
            if (w) req1 = 1'b0;
            else   req0 = 1'b0;
            if (!got) begin
               pend[0] = 1'b0; pend[1] = 1'b0;
               req0 = 1'b0; req1 = 1'b0;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         ram_mem[i]   = '0;
         model_mem[i] = '0;
      end
      model_reset();
      test_reset();
      test_single_write();
      test_read_back();
      test_tie();
      test_stale_guard();
      test_reset_mid_issue();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer for a single `single_port_ram` instance. It sits between two independent memory clients (for example, two `bramctrlsimple`-style controllers) and the RAM's `clk/we/data/out/addr` pins. It serialises their read and write accesses through a fixed four-state handshake and returns read data and a one-cycle acknowledge to the winning client. Arbitration is round-robin when configured; otherwise requester 0 has fixed priority.

## Interface
Parameters:
- `ADDR_WIDTH`, 4, RAM address width in bits.
- `DATA_WIDTH`, 4, RAM data width in bits.

Ports:
- `clk`  in  1  single clock; every register samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request from requester 0 or 1; held high until the matching ack.
- `we0` / `we1`  in  1  1 = write, 0 = read; held stable while req is high.
- `addr0` / `addr1`  in  `ADDR_WIDTH`  access address; held stable while req is high.
- `wdata0` / `wdata1`  in  `DATA_WIDTH`  write data; held stable while req is high.
- `ack0` / `ack1`  out  1  registered one-cycle completion pulse.
- `rdata0` / `rdata1`  out  `DATA_WIDTH`  registered read data, valid while ack is high; holds its value otherwise.
- `ram_we`  out  1  drives the RAM `we` pin.
- `ram_addr`  out  `ADDR_WIDTH`  drives the RAM `addr` pin.
- `ram_data`  out  `DATA_WIDTH`  drives the RAM `data` pin.
- `ram_out`  in  `DATA_WIDTH`  from the RAM `out` pin; its registered output is valid one cycle after the address is sampled.

## Operation
The state machine has four states: IDLE, ISSUE, WAIT and DONE.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, the arbitration rule decides (see Configuration).
  - On a grant, register the winner's `addr`, `wdata` and `we` into `ram_addr`, `ram_data` and `ram_we`, record the winner in `gnt_id`, and go to ISSUE.
- **ISSUE:** RAM pins are stable, and the RAM samples them at the end of this cycle. At that edge `ram_we` is cleared, and the state moves to WAIT.
- **WAIT:** `ram_out` holds the read result.
  - At the end of this cycle, for a read, `rdata[gnt_id] <= ram_out`.
  - For a write, `rdata` is unchanged.
  - At the same edge, `ack[gnt_id] <= 1`, and the state moves to DONE.
- **DONE:** ack is high for exactly this cycle. Requests are not sampled in DONE. At the end of the cycle ack is cleared, `last_gnt <= gnt_id`, and the state returns to IDLE.
- The losing requester keeps `req` high and is served in the next IDLE cycle.
- Requests are never queued. A request that drops before it is granted is lost, with no error.
- Only `ram_we` is cleared after ISSUE. `ram_addr` and `ram_data` hold their last values.

## Timing
- **Reset values:** state = IDLE; `ack0` = `ack1` = 0; `rdata0` = `rdata1` = 0; `ram_we` = 0; `ram_addr` = 0; `ram_data` = 0; `last_gnt` = 1, so requester 0 wins the first tie.
- **Latency:** if `req` is sampled high at the end of cycle T (IDLE), RAM pins are driven in T+1, data is captured at the end of T+2, and ack is high in T+3.
- **Throughput:** at most one access every 4 cycles.
- **Requester obligation:** drop or change `req` in the cycle after ack (T+4). `req` seen during DONE is ignored, so a stale request cannot be re-granted.
- **Reset mid-operation:** reset forces IDLE at the next edge, with `ram_we` and both acks at 0.
  - A write whose ISSUE edge has already passed is committed to the RAM but never acked.
  - The requester must reissue the access.
- **Write-then-read to the same address:** ordered by grant sequence. The read returns the new data.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:** when both requests are high in IDLE, grant the requester that is not `last_gnt`.
- **`ARB_ROUND_ROBIN_EN` undefined:** requester 0 always wins ties. `last_gnt` is still maintained but ignored, so requester 1 can starve under continuous `req0`.

## Test plan
- **Reset then single write:** reset 2 cycles; `req0=1, we0=1, addr0=4'h3, wdata0=4'hA`. Required: `ram_we=1` with `ram_addr=3` and `ram_data=A` in T+1, `ack0` pulses in T+3, `ack1` stays 0.
- **Read-back:** after the previous test, `req1=1, we1=0, addr1=4'h3`. Required: `ack1` in T+3 with `rdata1=4'hA`, and `rdata0` unchanged.
- **Simultaneous requests, round robin (macro defined):** both requests held high for two accesses. Required: `ack0` in cycle 3, then `ack1` in cycle 7.
- **Simultaneous requests, fixed priority (macro undefined):** both held for 3 accesses. Required: `ack0` three times and `ack1` never.
- **Reset mid-ISSUE:** write of 4'h5 to addr 7, with reset asserted during ISSUE. Required: no ack, `ram_we=0` the next cycle, state IDLE, and a later read of addr 7 returns 4'h5.
- **Stale-request guard:** hold `req0` high through DONE and drop it at T+4. Required: exactly one `ack0` and no second grant.
